// File: rtl/pmic_pkg.sv
// Shared constants and types for the PMIC sequencing timer bank.
// Exposes timer widths, timer indices, one-hot start codes and the timer state type.
package pmic_pkg;

    localparam int N_TMR   = 5;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 8;
    localparam int CFG_AW  = 3;

    localparam logic [CNT_W-1:0] DEF_DELAY = 16'd100;

    localparam int TMR_T1 = 0;
    localparam int TMR_T2 = 1;
    localparam int TMR_T3 = 2;
    localparam int TMR_T4 = 3;
    localparam int TMR_T5 = 4;

    localparam logic [N_TMR-1:0] SEL_NULL = 5'b00000;
    localparam logic [N_TMR-1:0] SEL_T1   = 5'b00001;
    localparam logic [N_TMR-1:0] SEL_T2   = 5'b00010;
    localparam logic [N_TMR-1:0] SEL_T3   = 5'b00100;
    localparam logic [N_TMR-1:0] SEL_T4   = 5'b01000;
    localparam logic [N_TMR-1:0] SEL_T5   = 5'b10000;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    function automatic logic is_onehot(input logic [N_TMR-1:0] v);
        return (v != '0) && ((v & (v - N_TMR'(1))) == '0);
    endfunction

endpackage

// File: rtl/pmic_seq_timer_bank_if.sv
// Bus between the sequencing FSM / config port and the timer bank.
// master: drives sel, ld, abort, presc, cfg_*; slave: drives T, busy, sel_err, cfg_err.
interface pmic_seq_timer_bank_if;
    import pmic_pkg::*;

    logic [N_TMR-1:0]   sel;
    logic               ld;
    logic               abort;
    logic [PRESC_W-1:0] presc;
    logic               cfg_we;
    logic [CFG_AW-1:0]  cfg_addr;
    logic [CNT_W-1:0]   cfg_wdata;
    logic [N_TMR-1:0]   T;
    logic               busy;
    logic               sel_err;
    logic               cfg_err;

    modport master (
        output sel, ld, abort, presc, cfg_we, cfg_addr, cfg_wdata,
        input  T, busy, sel_err, cfg_err
    );

    modport slave (
        input  sel, ld, abort, presc, cfg_we, cfg_addr, cfg_wdata,
        output T, busy, sel_err, cfg_err
    );

endinterface

// File: rtl/pmic_delay_timer.sv
// Single sequencing delay timer: counter, run flag and registered done pulse.
// Ports: clk, reset, tick, start, abort, dly in; done (1-cycle pulse), run out.
module pmic_delay_timer
    import pmic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dly,
    output logic             done,
    output logic             run
);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = TMR_IDLE;
        end else begin
            if (state_q == TMR_RUN) begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = TMR_IDLE;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // A start overrides the current run; an expiry in the same
            // cycle still reports done for the old run.
            if (start) begin
                state_d = TMR_RUN;
                cnt_d   = dly;
            end
        end
    end

    assign done = done_q;
    assign run  = (state_q == TMR_RUN);

endmodule

// File: rtl/pmic_seq_timer_bank.sv
// Bank of N_TMR programmable sequencing-delay timers with shared prescaler.
// Ports: clk, reset (async, active-high), bus (slave side of pmic_seq_timer_bank_if).
module pmic_seq_timer_bank
    import pmic_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEF_DLY = DEF_DELAY
) (
    input logic                  clk,
    input logic                  reset,
    pmic_seq_timer_bank_if.slave bus
);

    logic [PRESC_W-1:0] pcnt_q;
    logic               tick;
    logic [CNT_W-1:0]   dly_q [N_TMR];
    logic               sel_ok;
    logic [N_TMR-1:0]   start;
    logic [N_TMR-1:0]   done;
    logic [N_TMR-1:0]   run;
    logic               sel_err_q;
    logic               cfg_err_q;
    logic               addr_ok;

    assign tick = (pcnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
        end else if (tick) begin
            pcnt_q <= bus.presc;
        end else begin
            pcnt_q <= pcnt_q - PRESC_W'(1);
        end
    end

    assign sel_ok = is_onehot(bus.sel);
    assign start  = (bus.ld && sel_ok && !bus.abort) ? bus.sel : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (bus.ld && !sel_ok) begin
            sel_err_q <= 1'b1;
        end
    end

    assign addr_ok = (bus.cfg_addr < CFG_AW'(N_TMR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TMR; i++) begin
                dly_q[i] <= DEF_DLY;
            end
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && !addr_ok;
            for (int i = 0; i < N_TMR; i++) begin
                if (bus.cfg_we && bus.cfg_addr == CFG_AW'(i)) begin
                    dly_q[i] <= bus.cfg_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < N_TMR; g++) begin : g_tmr
        pmic_delay_timer u_tmr (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .start (start[g]),
            .abort (bus.abort),
            .dly   (dly_q[g]),
            .done  (done[g]),
            .run   (run[g])
        );
    end

    // Run flags are registers, so busy drops on the same edge as the
    // final done pulse.
    assign bus.T       = done;
    assign bus.busy    = |run;
    assign bus.sel_err = sel_err_q;
    assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pmic_seq_timer_bank.sv
// Directed self-checking bench for pmic_seq_timer_bank.
// Drives and samples on the falling edge; latencies count rising edges after the ld edge.
module tb_pmic_seq_timer_bank;
    import pmic_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    pmic_seq_timer_bank_if bif ();

    pmic_seq_timer_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic cfg_wr(input int a, input int d);
        bif.cfg_we    = 1'b1;
        bif.cfg_addr  = CFG_AW'(a);
        bif.cfg_wdata = CNT_W'(d);
        @(negedge clk);
        bif.cfg_we = 1'b0;
    endtask

    task automatic launch(input logic [N_TMR-1:0] s);
        bif.sel = s;
        bif.ld  = 1'b1;
        @(negedge clk);
        bif.ld  = 1'b0;
        bif.sel = '0;
    endtask

    // Watch T[idx] for maxc cycles after a launch; first pulse and pulse count.
    task automatic watch(input int idx, input int maxc,
                         output int lat, output int np);
        lat = -1;
        np  = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (bif.T[idx]) begin
                np++;
                if (lat < 0) lat = c;
            end
        end
    endtask

    int lat, np, b1, b100, b101;
    logic [N_TMR-1:0] tv [8];
    logic bv [8];

    initial begin
        n_chk = 0;
        n_pass = 0;
        bif.sel = '0;
        bif.ld = 1'b0;
        bif.abort = 1'b0;
        bif.presc = '0;
        bif.cfg_we = 1'b0;
        bif.cfg_addr = '0;
        bif.cfg_wdata = '0;
        do_reset();

        chk("rst_T", int'(bif.T), 0);
        chk("rst_busy", int'(bif.busy), 0);
        chk("rst_sel_err", int'(bif.sel_err), 0);
        chk("rst_cfg_err", int'(bif.cfg_err), 0);

        // Default delay 100, presc 0.
        launch(SEL_T1);
        lat = -1; np = 0; b1 = 0; b100 = 0; b101 = 1;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 1) b1 = int'(bif.busy);
            if (c == 100) b100 = int'(bif.busy);
            if (c == 101) b101 = int'(bif.busy);
            if (bif.T[TMR_T1]) begin
                np++;
                if (lat < 0) lat = c;
            end
        end
        chk("def_lat", lat, 101);
        chk("def_np", np, 1);
        chk("def_busy1", b1, 1);
        chk("def_busy100", b100, 1);
        chk("def_busy101", b101, 0);

        // Programmed delays.
        cfg_wr(1, 3);
        cfg_wr(4, 0);
        launch(SEL_T2);
        watch(TMR_T2, 10, lat, np);
        chk("d3_lat", lat, 4);
        chk("d3_np", np, 1);
        launch(SEL_T5);
        watch(TMR_T5, 5, lat, np);
        chk("d0_lat", lat, 1);
        chk("d0_np", np, 1);

        // Write and load same edge: old value 3 used, new value 7 next time.
        bif.cfg_we = 1'b1;
        bif.cfg_addr = 3'd1;
        bif.cfg_wdata = 16'd7;
        launch(SEL_T2);
        bif.cfg_we = 1'b0;
        watch(TMR_T2, 12, lat, np);
        chk("wrld_old_lat", lat, 4);
        launch(SEL_T2);
        watch(TMR_T2, 12, lat, np);
        chk("wrld_new_lat", lat, 8);

        // Prescaler 3, delay 2: 6..9 cycles.
        bif.presc = 8'd3;
        cfg_wr(2, 2);
        repeat (3) @(negedge clk);
        launch(SEL_T3);
        watch(TMR_T3, 15, lat, np);
        chk("presc_lat_in_range", int'(lat >= 6 && lat <= 9), 1);
        chk("presc_np", np, 1);
        // D = 0 is independent of prescaler.
        launch(SEL_T5);
        watch(TMR_T5, 5, lat, np);
        chk("presc_d0_lat", lat, 1);
        bif.presc = '0;
        repeat (5) @(negedge clk);

        // Restart: ld at cycle 0 and cycle 5, delay 10.
        cfg_wr(0, 10);
        launch(SEL_T1);
        lat = -1; np = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                bif.sel = SEL_T1;
                bif.ld = 1'b1;
            end
            @(negedge clk);
            bif.ld = 1'b0;
            bif.sel = '0;
            if (bif.T[TMR_T1]) begin
                np++;
                if (lat < 0) lat = c;
            end
        end
        chk("restart_lat", lat, 16);
        chk("restart_np", np, 1);

        // Abort at cycle 5.
        launch(SEL_T1);
        np = 0; b1 = 1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) bif.abort = 1'b1;
            @(negedge clk);
            bif.abort = 1'b0;
            if (c == 5) b1 = int'(bif.busy);
            if (bif.T[TMR_T1]) np++;
        end
        chk("abort_busy", b1, 0);
        chk("abort_np", np, 0);

        // Abort beats same-edge ld.
        bif.abort = 1'b1;
        launch(SEL_T2);
        bif.abort = 1'b0;
        chk("abort_ld_busy", int'(bif.busy), 0);
        watch(TMR_T2, 10, lat, np);
        chk("abort_ld_np", np, 0);

        // Bad select.
        launch(5'b00011);
        chk("selerr_busy", int'(bif.busy), 0);
        chk("selerr_set", int'(bif.sel_err), 1);
        watch(TMR_T1, 12, lat, np);
        chk("selerr_no_t1", np, 0);
        launch(SEL_T5);
        chk("selerr_sticky", int'(bif.sel_err), 1);
        @(negedge clk);

        // Bad config address.
        cfg_wr(6, 55);
        chk("cfgerr_pulse", int'(bif.cfg_err), 1);
        @(negedge clk);
        chk("cfgerr_clear", int'(bif.cfg_err), 0);
        launch(SEL_T2);
        watch(TMR_T2, 12, lat, np);
        chk("cfgerr_dly_kept", lat, 8);

        // Reset clears sel_err and restores defaults.
        do_reset();
        chk("rst2_sel_err", int'(bif.sel_err), 0);

        // Concurrency: T1 at edge 0, T4 at edge 1, both delay 2.
        cfg_wr(0, 2);
        cfg_wr(3, 2);
        bif.sel = SEL_T1;
        bif.ld = 1'b1;
        @(negedge clk);
        bif.sel = SEL_T4;
        @(negedge clk);
        bif.ld = 1'b0;
        bif.sel = '0;
        tv[0] = bif.T;
        bv[0] = bif.busy;
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            tv[c-1] = bif.T;
            bv[c-1] = bif.busy;
        end
        // tv[k] holds T after edge k+1 relative to the T1 ld edge.
        chk("conc_t1", int'(tv[2]), int'(SEL_T1));
        chk("conc_t4", int'(tv[3]), int'(SEL_T4));
        chk("conc_busy_mid", int'(bv[2]), 1);
        chk("conc_busy_end", int'(bv[3]), 0);
        chk("conc_quiet", int'(tv[4]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
